cnt_share_arb: RTL

//  Shares one loadable 8-bit down counter (ld_cnt/cnt/init in, co out, co = counter nonzero)

---
 rtl/cnt_arb_pkg.sv | 26 ++
 rtl/cnt_share_arb_if.sv | 31 +++
 rtl/cnt_arb_rr_pick.sv | 34 +++
 rtl/cnt_share_arb.sv | 129 ++++++++++++
 4 files changed

// File: rtl/cnt_arb_pkg.sv
// Shared types and constants for the counter-sharing arbiter.
// States, default sizes and small index helpers used by the arbiter,
// its round-robin picker and the bus interface.
package cnt_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 8;

    // Width of a requester index; at least one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Reduce v into 0..n-1 when v is known to lie in 0..2n-1.
    function automatic int wrap_idx(input int v, input int n);
        return (v >= n) ? (v - n) : v;
    endfunction

endpackage

// File: rtl/cnt_share_arb_if.sv
// Bundle between the requesting FSMs / external down counter and the
// counter-sharing arbiter. The arbiter uses the slave view; the
// surrounding logic (requesters and counter) uses the master view.
interface cnt_share_arb_if
    import cnt_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] init_in;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic                  cnt_ld;
    logic                  cnt_en;
    logic [WIDTH-1:0]      cnt_init;
    logic                  cnt_co;

    modport slave (
        input  req, init_in, cnt_co,
        output gnt, done, busy, cnt_ld, cnt_en, cnt_init
    );

    modport master (
        output req, init_in, cnt_co,
        input  gnt, done, busy, cnt_ld, cnt_en, cnt_init
    );

endinterface

// File: rtl/cnt_arb_rr_pick.sv
// Combinational round-robin picker: finds the first active request at
// or after the pointer, wrapping past the top requester.
module cnt_arb_rr_pick
    import cnt_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDXW = idx_width(NREQ_DEF)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic [NREQ-1:0] gnt_oh_o,
    output logic [IDXW-1:0] idx_o,
    output logic            vld_o
);

    logic [IDXW-1:0] cand;

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        cand     = '0;
        gnt_oh_o = '0;
        idx_o    = '0;
        vld_o    = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            cand = IDXW'(wrap_idx(int'(ptr_i) + off, NREQ));
            if (!vld_o && req_i[cand]) begin
                vld_o          = 1'b1;
                idx_o          = cand;
                gnt_oh_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnt_share_arb.sv
// Shares one external loadable down counter between NREQ requesters.
// A granted requester gets its own init value loaded, the counter runs
// until its nonzero flag drops, then the owner sees a one-cycle done.
// Optional feature: define CNT_ARB_ABORT_EN to let an owner cancel its
// grant by dropping req during LOAD or RUN (no done pulse in that case).
module cnt_share_arb
    import cnt_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input logic            clk,
    input logic            rst,
    cnt_share_arb_if.slave bus
);

    localparam int IDXW = idx_width(NREQ);

    state_e          state_q;
    logic [IDXW-1:0] owner_q;
    logic [IDXW-1:0] ptr_q;
    logic [IDXW-1:0] ptr_d;
    logic [WIDTH-1:0] init_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] done_q;
    logic            busy_q;
    logic            ld_q;

    logic [NREQ-1:0] pick_oh;
    logic [IDXW-1:0] pick_idx;
    logic            pick_vld;
    logic [WIDTH-1:0] pick_init;
    logic            abort;

    cnt_arb_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .gnt_oh_o (pick_oh),
        .idx_o    (pick_idx),
        .vld_o    (pick_vld)
    );

    // Delay value of the requester about to be granted.
    assign pick_init = bus.init_in[int'(pick_idx)*WIDTH +: WIDTH];

    // Fairness: the next scan starts just past the requester served last.
    assign ptr_d = IDXW'(wrap_idx(int'(owner_q) + 1, NREQ));

`ifdef CNT_ARB_ABORT_EN
    // The owner releasing its request before completion cancels the grant.
    assign abort = ((state_q == ST_LOAD) || (state_q == ST_RUN)) &&
                   ((bus.req & gnt_q) == '0);
`else
    assign abort = 1'b0;
`endif

    // Counting follows the counter's own nonzero flag so it stops exactly at zero.
    assign bus.cnt_en   = (state_q == ST_RUN) && bus.cnt_co && !abort;
    assign bus.cnt_ld   = ld_q;
    assign bus.cnt_init = init_q;
    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;

    // Grant FSM with registered outputs; IDLE always separates two grants.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            init_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            ld_q    <= 1'b0;
        end else begin
            done_q <= '0;
            ld_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state_q <= ST_LOAD;
                        owner_q <= pick_idx;
                        init_q  <= pick_init;
                        gnt_q   <= pick_oh;
                        busy_q  <= 1'b1;
                        ld_q    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= ptr_d;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= ptr_d;
                    end else if (!bus.cnt_co) begin
                        state_q <= ST_DONE;
                        done_q  <= gnt_q;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= ptr_d;
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
